// File: rtl/dreg_bank_pkg.sv
// Shared types and constants for the dreg_bank register bank and its channels.
package dreg_bank_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_SHR  = 2'b11
    } mode_e;

    localparam int               CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

endpackage

// File: rtl/dreg_channel.sv
// One WIDTH-bit register channel: mode/clear/enable mux, serial tap and optional
// registered even parity (enabled by defining DREG_BANK_PARITY_EN).
module dreg_channel
    import dreg_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] notq,
    output logic             ser_out,
    output logic [WIDTH-1:0] q_next
`ifdef DREG_BANK_PARITY_EN
    ,
    output logic             par
`endif
);

    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shr_val;

    // A 1-bit register has nothing to shift, so both directions just take ser_in.
    generate
        if (WIDTH == 1) begin : g_w1
            assign shl_val = ser_in;
            assign shr_val = ser_in;
        end else begin : g_wn
            assign shl_val = {q[WIDTH-2:0], ser_in};
            assign shr_val = {ser_in, q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        q_next = q;
        if (en) begin
            if (clr) begin
                q_next = '0;
            end else begin
                case (mode)
                    MODE_HOLD: q_next = q;
                    MODE_LOAD: q_next = d;
                    MODE_SHL:  q_next = shl_val;
                    MODE_SHR:  q_next = shr_val;
                    default:   q_next = q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

`ifdef DREG_BANK_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par <= 1'b0;
        end else begin
            par <= ^q_next;
        end
    end
`endif

    assign notq    = ~q;
    // The tap follows the live mode so a direction change moves it immediately.
    assign ser_out = (mode == MODE_SHR) ? q[0] : q[WIDTH-1];

endmodule

// File: rtl/dreg_bank.sv
// Multi-channel clocked D-register bank with change pulse and saturating update
// counter. Defining DREG_BANK_PARITY_EN adds the per-channel par output.
module dreg_bank
    import dreg_bank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                mode,
    input  logic                      clr,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [CHANNELS-1:0]       ser_in,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS*WIDTH-1:0] notq,
    output logic [CHANNELS-1:0]       ser_out,
    output logic                      changed,
    output logic [CNT_W-1:0]          upd_cnt
`ifdef DREG_BANK_PARITY_EN
    ,
    output logic [CHANNELS-1:0]       par
`endif
);

    logic [CHANNELS*WIDTH-1:0] q_next;
    logic                      change_now;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        dreg_channel #(.WIDTH(WIDTH)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .mode    (mode),
            .clr     (clr),
            .en      (ch_en[i]),
            .d       (d[i*WIDTH +: WIDTH]),
            .ser_in  (ser_in[i]),
            .q       (q[i*WIDTH +: WIDTH]),
            .notq    (notq[i*WIDTH +: WIDTH]),
            .ser_out (ser_out[i]),
            .q_next  (q_next[i*WIDTH +: WIDTH])
`ifdef DREG_BANK_PARITY_EN
            ,
            .par     (par[i])
`endif
        );
    end

    // Comparing next against current state lets changed land with the new q.
    assign change_now = (q_next != q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed <= 1'b0;
            upd_cnt <= '0;
        end else begin
            changed <= change_now;
            if (change_now && (upd_cnt != CNT_MAX)) begin
                upd_cnt <= upd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dreg_bank.sv
// Scoreboard testbench for dreg_bank: directed vectors push expectations, a
// monitor pops and compares them on every falling clock edge.
module tb_dreg_bank;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic [1:0]     mode;
    logic           clr;
    logic [N-1:0]   ch_en;
    logic [N*W-1:0] d;
    logic [N-1:0]   ser_in;
    logic [N*W-1:0] q;
    logic [N*W-1:0] notq;
    logic [N-1:0]   ser_out;
    logic           changed;
    logic [7:0]     upd_cnt;
`ifdef DREG_BANK_PARITY_EN
    logic [N-1:0]   par;
`endif

    typedef struct {
        int             id;
        logic [N*W-1:0] q;
        logic           chg;
        logic [7:0]     cnt;
        logic [1:0]     mode;
    } exp_t;

    exp_t sb[$];
    event sample_ev;
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    dreg_bank #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode),
        .clr     (clr),
        .ch_en   (ch_en),
        .d       (d),
        .ser_in  (ser_in),
        .q       (q),
        .notq    (notq),
        .ser_out (ser_out),
        .changed (changed),
        .upd_cnt (upd_cnt)
`ifdef DREG_BANK_PARITY_EN
        ,
        .par     (par)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) -> sample_ev;

    function automatic logic [N-1:0] exp_ser_out(input logic [N*W-1:0] qv, input logic [1:0] m);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = (m == 2'b11) ? qv[i*W] : qv[i*W + W - 1];
        end
        return r;
    endfunction

    function automatic logic [N-1:0] exp_par(input logic [N*W-1:0] qv);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = ^qv[i*W +: W];
        end
        return r;
    endfunction

    task automatic check_output(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s vec=%0d actual=%h expected=%h", name, id, act, exp);
        end
    endtask

    task automatic push_exp(input logic [N*W-1:0] eq, input logic ec, input logic [7:0] en_cnt, input logic [1:0] m);
        exp_t e;
        e.id   = vec_id;
        e.q    = eq;
        e.chg  = ec;
        e.cnt  = en_cnt;
        e.mode = m;
        sb.push_back(e);
        vec_id++;
    endtask

    // Drives one vector mid-low-phase, lets one rising edge pass, queues the expectation.
    task automatic apply_stimulus(input logic [1:0] m, input logic c, input logic [N-1:0] en,
                                  input logic [N*W-1:0] dv, input logic [N-1:0] si,
                                  input logic [N*W-1:0] eq, input logic ec, input logic [7:0] ecnt);
        @(negedge clk);
        #1;
        mode   = m;
        clr    = c;
        ch_en  = en;
        d      = dv;
        ser_in = si;
        @(posedge clk);
        #1;
        push_exp(eq, ec, ecnt, m);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(sample_ev);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_output("q", e.id, q, e.q);
                check_output("notq", e.id, notq, ~e.q);
                check_output("changed", e.id, 32'(changed), 32'(e.chg));
                check_output("upd_cnt", e.id, 32'(upd_cnt), 32'(e.cnt));
                check_output("ser_out", e.id, 32'(ser_out), 32'(exp_ser_out(e.q, e.mode)));
`ifdef DREG_BANK_PARITY_EN
                check_output("par", e.id, 32'(par), 32'(exp_par(e.q)));
`endif
            end
        end
    end

    initial begin : stimulus
        logic [7:0] cnt_model;
        logic [7:0] v;
        rst_n  = 1'b0;
        mode   = 2'b00;
        clr    = 1'b0;
        ch_en  = '0;
        d      = '0;
        ser_in = '0;
        #1;
        push_exp(32'h0000_0000, 1'b0, 8'd0, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        apply_stimulus(2'b01, 1'b0, 4'b0001, 32'h1111_11A5, 4'b0000, 32'h0000_00A5, 1'b1, 8'd1);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(2'b01, 1'b0, 4'b0000, 32'hFFFF_FFFF, 4'b1111, 32'h0000_00A5, 1'b0, 8'd1);
        end

        apply_stimulus(2'b01, 1'b0, 4'b0001, 32'h0000_0081, 4'b0000, 32'h0000_0081, 1'b1, 8'd2);
        apply_stimulus(2'b10, 1'b0, 4'b0001, 32'h0000_0000, 4'b1110, 32'h0000_0002, 1'b1, 8'd3);
        apply_stimulus(2'b11, 1'b0, 4'b0001, 32'h0000_0000, 4'b1111, 32'h0000_0081, 1'b1, 8'd4);

        apply_stimulus(2'b01, 1'b0, 4'b1111, 32'h4433_2211, 4'b0000, 32'h4433_2211, 1'b1, 8'd5);
        apply_stimulus(2'b01, 1'b1, 4'b0101, 32'h3333_3333, 4'b0000, 32'h4400_2200, 1'b1, 8'd6);
        apply_stimulus(2'b01, 1'b1, 4'b0101, 32'h3333_3333, 4'b0000, 32'h4400_2200, 1'b0, 8'd6);
        apply_stimulus(2'b00, 1'b0, 4'b1111, 32'hFFFF_FFFF, 4'b1111, 32'h4400_2200, 1'b0, 8'd6);
        apply_stimulus(2'b01, 1'b0, 4'b1111, 32'h4400_2200, 4'b0000, 32'h4400_2200, 1'b0, 8'd6);
        apply_stimulus(2'b10, 1'b0, 4'b0100, 32'h0000_0000, 4'b0000, 32'h4400_2200, 1'b0, 8'd6);

        cnt_model = 8'd6;
        for (int i = 0; i < 300; i++) begin
            v = (i % 2 == 0) ? 8'hFF : 8'h00;
            if (cnt_model != 8'd255) cnt_model = cnt_model + 8'd1;
            apply_stimulus(2'b01, 1'b0, 4'b0001, {24'h000000, v}, 4'b0000,
                           {24'h440022, v}, 1'b1, cnt_model);
        end

        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        push_exp(32'h0000_0000, 1'b0, 8'd0, 2'b01);
        -> sample_ev;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        apply_stimulus(2'b01, 1'b0, 4'b0001, 32'h0000_0007, 4'b0000, 32'h0000_0007, 1'b1, 8'd1);
        apply_stimulus(2'b01, 1'b0, 4'b0001, 32'h0000_0003, 4'b0000, 32'h0000_0003, 1'b1, 8'd2);
        apply_stimulus(2'b11, 1'b0, 4'b0001, 32'h0000_0000, 4'b0001, 32'h0000_0081, 1'b1, 8'd3);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain actual=%0d pending expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
